// File: rtl/io_responder.sv
// ---------------------------------------------------------------------------
// io_responder
//
// Memory-mapped IO slave on the CPU's IO space. It holds the LED output
// register, a synchronised and debounced copy of the 16 board switches,
// sticky switch-change flags and a 16-bit prescaled countdown timer.
//
// Register map (addr, low byte of the IO address):
//   0x60 LED    read/write
//   0x70 SW     read-only, debounced switch value
//   0x74 SWCHG  read, clear-on-read; bit i sets when SW bit i changes
//   0x80 TLOAD  write-only (reads 0); loads the count and starts the timer
//   0x84 TSTAT  read; bit0 running, bit1 expired (sticky, clear-on-read)
//   others      read 0, writes ignored
//
// Ports:
//   clock      system clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   io_read    IO read strobe (already qualified as IO space)
//   io_write   IO write strobe (already qualified as IO space)
//   addr[7:0]  IO address low byte
//   wdata[15:0] write data
//   rdata[15:0] read data, combinational from addr, 0 when io_read=0
//   switch[15:0] raw asynchronous board switches
//   led[15:0]  LED register
//   timer_irq  level interrupt, equal to the expired flag
// ---------------------------------------------------------------------------
module io_responder #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TIMER_PRESCALE  = 1000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic [15:0] switch,
    output logic [15:0] led,
    output logic        timer_irq
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [7:0] ADDR_LED   = 8'h60;
    localparam logic [7:0] ADDR_SW    = 8'h70;
    localparam logic [7:0] ADDR_SWCHG = 8'h74;
    localparam logic [7:0] ADDR_TLOAD = 8'h80;
    localparam logic [7:0] ADDR_TSTAT = 8'h84;

    localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (TIMER_PRESCALE  > 1) ? $clog2(TIMER_PRESCALE)  : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_PRESCALE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tstate_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]   led_q,      led_d;
    logic [15:0]   sync1_q;
    logic [15:0]   sync2_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0]   s1_q,       s1_d;
    logic [15:0]   s2_q,       s2_d;
    logic [15:0]   sw_q,       sw_d;
    logic [15:0]   swchg_q,    swchg_d;
    tstate_e       state_q,    state_d;
    logic [15:0]   count_q,    count_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic          expired_q,  expired_d;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic        wr_led_s;
    logic        wr_tload_s;
    logic        rd_swchg_s;
    logic        rd_tstat_s;
    logic        tick_s;
    logic [15:0] stable_s;
    logic [15:0] sw_change_s;
    logic        expire_set_s;
    logic        running_s;

    assign wr_led_s   = io_write && (addr == ADDR_LED);
    assign wr_tload_s = io_write && (addr == ADDR_TLOAD);
    assign rd_swchg_s = io_read  && (addr == ADDR_SWCHG);
    assign rd_tstat_s = io_read  && (addr == ADDR_TSTAT);

    assign running_s  = (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------

    // LED next value: replaced on a write to its address, otherwise held.
    always_comb begin
        led_d = led_q;
        if (wr_led_s) begin
            led_d = wdata;
        end else begin
            led_d = led_q;
        end
    end

    // ------------------------------------------------------------------
    // Switch path: synchroniser, sample tick, 3-sample debounce
    // ------------------------------------------------------------------
    assign tick_s = (tick_cnt_q == TICK_LAST);

    // A bit is stable when the current synchronised sample matches the two
    // previous tick samples.
    assign stable_s = ~(sync2_q ^ s1_q) & ~(sync2_q ^ s2_q);

    // Tick counter next value: wraps every DEBOUNCE_CYCLES cycles.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Debounce shift register and debounced value, advanced only on a tick.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        sw_d = sw_q;
        if (tick_s) begin
            s1_d = sync2_q;
            s2_d = s1_q;
            sw_d = (stable_s & sync2_q) | (~stable_s & sw_q);
        end else begin
            s1_d = s1_q;
            s2_d = s2_q;
            sw_d = sw_q;
        end
    end

    assign sw_change_s = sw_d ^ sw_q;

    // Change flags: clear-on-read, but a change in the same cycle keeps its
    // bit set because the event is ORed in after the clear.
    always_comb begin
        swchg_d = swchg_q;
        if (rd_swchg_s) begin
            swchg_d = sw_change_s;
        end else begin
            swchg_d = swchg_q | sw_change_s;
        end
    end

    // ------------------------------------------------------------------
    // Countdown timer
    // ------------------------------------------------------------------

    // Timer FSM next state: load/restart on TLOAD writes, otherwise count
    // down once per prescaler wrap and expire on the 1->0 step.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        presc_d      = presc_q;
        expire_set_s = 1'b0;
        if (wr_tload_s) begin
            presc_d = '0;
            if (wdata == 16'h0000) begin
                // A zero load expires immediately without running.
                state_d      = ST_IDLE;
                count_d      = 16'h0000;
                expire_set_s = 1'b1;
            end else begin
                state_d = ST_RUN;
                count_d = wdata;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
                ST_RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        // Saturate at zero; reaching it ends the run.
                        if (count_q <= 16'h0001) begin
                            count_d      = 16'h0000;
                            state_d      = ST_IDLE;
                            expire_set_s = 1'b1;
                        end else begin
                            count_d = count_q - 16'h0001;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 16'h0000;
                    presc_d = '0;
                end
            endcase
        end
    end

    // Expired flag: clear-on-read of TSTAT, with expiry taking priority.
    always_comb begin
        expired_d = expired_q;
        if (rd_tstat_s) begin
            expired_d = expire_set_s;
        end else begin
            expired_d = expired_q | expire_set_s;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // Two-flop synchroniser on the raw asynchronous switches.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q <= 16'h0000;
            sync2_q <= 16'h0000;
        end else begin
            sync1_q <= switch;
            sync2_q <= sync1_q;
        end
    end

    // Debounce and switch-flag registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            s1_q       <= 16'h0000;
            s2_q       <= 16'h0000;
            sw_q       <= 16'h0000;
            swchg_q    <= 16'h0000;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            sw_q       <= sw_d;
            swchg_q    <= swchg_d;
        end
    end

    // LED and timer registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            led_q     <= 16'h0000;
            state_q   <= ST_IDLE;
            count_q   <= 16'h0000;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Read mux: zero-latency view of the addressed register; a combined
    // read/write therefore returns the pre-write value.
    always_comb begin
        rdata = 16'h0000;
        if (io_read) begin
            case (addr)
                ADDR_LED:   rdata = led_q;
                ADDR_SW:    rdata = sw_q;
                ADDR_SWCHG: rdata = swchg_q;
                ADDR_TSTAT: rdata = {14'h0000, expired_q, running_s};
                default:    rdata = 16'h0000;
            endcase
        end else begin
            rdata = 16'h0000;
        end
    end

    assign led       = led_q;
    assign timer_irq = expired_q;

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

    logic        clock;
    logic        rst;
    logic        io_read;
    logic        io_write;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] switch;
    logic [15:0] led;
    logic        timer_irq;

    int n_vec;
    int n_err;

    io_responder #(
        .DEBOUNCE_CYCLES(4),
        .TIMER_PRESCALE (2)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .io_read  (io_read),
        .io_write (io_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .switch   (switch),
        .led      (led),
        .timer_irq(timer_irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [15:0] exp_led;
        logic        exp_irq;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle, leaving the bench just after the rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) until rdata equals want; returns cycles taken or 0.
    task automatic wait_rdata(input logic [15:0] want, input int limit, output int took);
        took = 0;
        for (int c = 1; c <= limit; c++) begin
            next_cycle();
            if (rdata === want) begin
                took = c;
                break;
            end
        end
    endtask

    initial begin
        int took;
        n_vec = 0;
        n_err = 0;

        // ---------------- Reset ----------------
        rst      = 1'b0;
        switch   = 16'hFFFF;
        io_read  = 1'b1;
        io_write = 1'b0;
        addr     = 8'h70;
        wdata    = 16'h0000;
        #20;
        check("reset_led", led, 16'h0000);
        check("reset_sw", rdata, 16'h0000);
        check("reset_irq", {15'h0, timer_irq}, 16'h0000);

        @(posedge clock);
        #1 rst = 1'b1;
        wait_rdata(16'hFFFF, 20, took);
        check("sw_settle_le_14", {15'h0, (took >= 1 && took <= 14)}, 16'h0001);
        addr = 8'h74;
        @(negedge clock);
        check("swchg_after_reset", rdata, 16'hFFFF);
        next_cycle();
        @(negedge clock);
        check("swchg_cleared", rdata, 16'h0000);

        // ---------------- Debounce ----------------
        next_cycle();
        addr   = 8'h70;
        switch = 16'h0000;
        wait_rdata(16'h0000, 20, took);
        check("sw_to_zero", {15'h0, (took != 0)}, 16'h0001);
        addr = 8'h74;
        next_cycle();      // clear-on-read of the pending flags
        @(negedge clock);
        check("swchg_zero_clear", rdata, 16'h0000);
        next_cycle();
        addr = 8'h70;
        // 1-cycle glitches every 3 cycles never give 3 equal tick samples.
        for (int k = 0; k < 8; k++) begin
            switch = 16'h0008;
            next_cycle();
            switch = 16'h0000;
            next_cycle();
            next_cycle();
        end
        for (int k = 0; k < 12; k++) next_cycle();
        check("glitch_sw", rdata, 16'h0000);
        addr = 8'h74;
        @(negedge clock);
        check("glitch_swchg", rdata, 16'h0000);
        next_cycle();
        addr   = 8'h70;
        switch = 16'h0008;
        wait_rdata(16'h0008, 16, took);
        check("hold_sw", rdata, 16'h0008);
        addr = 8'h74;
        @(negedge clock);
        check("swchg_bit3", rdata, 16'h0008);
        next_cycle();
        @(negedge clock);
        check("swchg_bit3_cleared", rdata, 16'h0000);
        next_cycle();

        // ---------------- Table-driven vectors ----------------
        //            rd    wr    addr   wdata     rdata     led       irq
        vecs[0]  = '{1'b0, 1'b1, 8'h60, 16'hA5A5, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h60, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h70, 16'h1234, 16'h0000, 16'hA5A5, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h70, 16'h0000, 16'h0008, 16'hA5A5, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h90, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h90, 16'hFFFF, 16'h0000, 16'hA5A5, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h60, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h60, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'h60, 16'h5A5A, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h60, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0};
        // timer: load 3, expires 6 cycles after the write edge
        vecs[10] = '{1'b0, 1'b1, 8'h80, 16'h0003, 16'h0000, 16'h5A5A, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h80, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0}; // read in expiry cycle
        vecs[17] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0002, 16'h5A5A, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        // TLOAD = 0
        vecs[19] = '{1'b0, 1'b1, 8'h80, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0002, 16'h5A5A, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        // reload when count = 1
        vecs[22] = '{1'b0, 1'b1, 8'h80, 16'h0002, 16'h0000, 16'h5A5A, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        vecs[26] = '{1'b0, 1'b1, 8'h80, 16'h0002, 16'h0000, 16'h5A5A, 1'b0};
        vecs[27] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[28] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[29] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[30] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0001, 16'h5A5A, 1'b0};
        vecs[31] = '{1'b0, 1'b0, 8'h84, 16'h0000, 16'h0000, 16'h5A5A, 1'b1};
        vecs[32] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0002, 16'h5A5A, 1'b1};
        vecs[33] = '{1'b1, 1'b0, 8'h84, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};

        for (int i = 0; i < NV; i++) begin
            io_read  = vecs[i].rd;
            io_write = vecs[i].wr;
            addr     = vecs[i].addr;
            wdata    = vecs[i].wdata;
            @(negedge clock);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
            check($sformatf("vec%0d_irq", i), {15'h0, timer_irq}, {15'h0, vecs[i].exp_irq});
            next_cycle();
        end

        // ---------------- Reset mid-RUN ----------------
        io_read  = 1'b0;
        io_write = 1'b1;
        addr     = 8'h80;
        wdata    = 16'h0005;
        next_cycle();
        io_write = 1'b0;
        io_read  = 1'b1;
        addr     = 8'h84;
        next_cycle();
        @(negedge clock);
        check("run_before_rst", rdata, 16'h0001);
        check("led_before_rst", led, 16'h5A5A);
        #2 rst = 1'b0;
        #1;
        check("rst_async_tstat", rdata, 16'h0000);
        check("rst_async_led", led, 16'h0000);
        check("rst_async_irq", {15'h0, timer_irq}, 16'h0000);
        next_cycle();
        rst = 1'b1;
        @(negedge clock);
        check("idle_after_rst", rdata, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
